pc_nextgen: RTL and testbench
=============================

Name: pc_nextgen

Overview:
- Parametrised program-counter unit for the MIPS fetch stage.
- Holds the PC register and computes PC+INC, the sign-extended branch offset and the branch, jump and jump-register targets.
- Applies redirects by fixed priority; a one-entry pending buffer keeps any redirect that arrives while fetch is stalled.
- Sits between the instruction-fetch address port and the ID/EX redirect logic.

Parameters:
- XLEN, 32: datapath width; must be >= 32.
- RESET_PC, 32'hBFC0_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180: exception entry address.
- INC, 4: sequential increment.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- stall  in  1  fetch hold; PC keeps its value
- exception  in  1  exception redirect request
- branch_taken  in  1  resolved taken branch
- branch_base  in  XLEN  PC of delay-slot instruction (branch PC+4)
- branch_imm  in  16  raw immediate
- jump  in  1  J/JAL redirect
- jump_index  in  26  instr_index field
- jump_reg  in  1  JR/JALR redirect
- jump_reg_target  in  XLEN  rs value
- pc  out  XLEN  current fetch address (registered)
- pc_next_seq  out  XLEN  pc+INC (combinational)
- signext  out  XLEN  sign-extended branch_imm (combinational)
- branch_target  out  XLEN  branch_base + (signext<<2) (combinational)
- redirected  out  1  registered; pc changed by a non-sequential source last edge
- addr_fault  out  1  registered one-cycle pulse, misaligned JR target
- fault_addr  out  XLEN  raw misaligned target, held until next fault

Behaviour:
- Reset (reset_n=0 at edge): pc=RESET_PC, pending_valid=0, redirected=0, addr_fault=0, fault_addr=0. Reset dominates all inputs, including mid-stall with a pending redirect.
- Arithmetic:
  - signext = {{XLEN-16{imm[15]}}, imm}.
  - All adds are modulo 2^XLEN; wrap-around is silent.
  - jump target = {branch_base[XLEN-1:28], jump_index, 2'b00}.
- Request priority: exception > jump_reg > jump > branch_taken > sequential. Only the winner's target is used.
- Update rule per edge (reset_n=1):
  - exception=1: pc<=EXC_VECTOR and pending cleared, regardless of stall.
  - Else stall=1 with a redirect request: the winner is captured into the pending buffer if pending_valid=0; if pending_valid=1, the pending target is kept (oldest wins). pc holds.
  - Else stall=1 with no request: pc holds, pending unchanged.
  - Else stall=0 with pending_valid=1: pc<=pending target and pending cleared. Any same-cycle branch/jump/jump_reg is ignored.
  - Else stall=0 with a request: pc<=winner target.
  - Else: pc<=pc+INC.
- Latency: a redirect is visible on pc one cycle after the request edge when unstalled, or on the first unstalled edge otherwise.
- redirected = 1 for one cycle after any edge where pc loaded a non-sequential value (exception, pending, direct redirect).
- Misalignment: if jump_reg wins and target[1:0]!=0:
  - pc loads target with [1:0] forced to 0.
  - addr_fault pulses the following cycle and fault_addr captures the raw target.
  - This also applies when the target is delivered later from the pending buffer.
- Branch/jump targets are always aligned; no check is made on them.

Decomposition:
- Package mips_pc_pkg:
  - default RESET_PC and EXC_VECTOR constants.
  - typedef of redirect source enum {SRC_SEQ, SRC_BR, SRC_J, SRC_JR, SRC_EXC}, used by the priority encoder and the pending-buffer source field.
- Sub-module branch_target_calc (combinational, XLEN-parametrised): sign-extend, shift, add; produces signext and branch_target.
- Top level holds the PC register, pending buffer, priority select and fault logic.

Test Plan:
- Reset then 3 free-running cycles -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; redirected=0.
- Branch: branch_base=00400010, imm=FFFE, branch_taken=1 -> signext=FFFFFFFE, branch_target=00400008; next cycle pc=00400008, redirected=1.
- Stall with redirects: stall=1, jump=1 (base=00400000, index=0000100) captured; next stalled cycle branch_taken=1 to 00400100 is ignored; stall drops -> pc=00000400.
- Exception priority: exception + jump_reg + branch same cycle while stall=1 -> pc=80000180 next edge and pending cleared.
- Misaligned JR: jump_reg_target=00401003 -> pc=00401000; addr_fault=1 for exactly one cycle; fault_addr=00401003.
- Wrap and reset: pc=FFFFFFFC, sequential step -> pc=00000000; then reset_n=0 with pending_valid=1 -> pc=BFC00000 and the pending redirect is never applied.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared constants and redirect-source encoding for the MIPS fetch-stage PC unit.
package mips_pc_pkg;

   localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
   localparam int          DEF_INC        = 4;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BR,
      SRC_J,
      SRC_JR,
      SRC_EXC
   } redirect_src_e;

endpackage

// File: rtl/pc_nextgen_branch_target_calc.sv
// Combinational branch target: sign-extend the 16-bit immediate, scale by 4, add to base.
module branch_target_calc #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] branch_base,
   input  logic [15:0]     branch_imm,
   output logic [XLEN-1:0] signext,
   output logic [XLEN-1:0] branch_target
);

   logic signed [XLEN-1:0] sext;
   logic signed [XLEN-1:0] offset;

   assign sext          = {{(XLEN-16){branch_imm[15]}}, branch_imm};
   assign offset        = sext <<< 2;
   assign signext       = sext;
   assign branch_target = branch_base + offset;

endmodule

// File: rtl/pc_nextgen.sv
// Fetch-stage program counter: priority redirect select, one-entry pending buffer
// for redirects arriving under stall, and misaligned jump-register fault capture.
module pc_nextgen
   import mips_pc_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
   parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEF_EXC_VECTOR),
   parameter int              INC        = DEF_INC
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            exception,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_base,
   input  logic [15:0]     branch_imm,
   input  logic            jump,
   input  logic [25:0]     jump_index,
   input  logic            jump_reg,
   input  logic [XLEN-1:0] jump_reg_target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next_seq,
   output logic [XLEN-1:0] signext,
   output logic [XLEN-1:0] branch_target,
   output logic            redirected,
   output logic            addr_fault,
   output logic [XLEN-1:0] fault_addr
);

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   logic [XLEN-1:0] jump_target;
   redirect_src_e   req_src;
   logic [XLEN-1:0] req_target;

   logic            pend_valid, pend_valid_d;
   redirect_src_e   pend_src, pend_src_d;
   logic [XLEN-1:0] pend_target, pend_target_d;

   logic            load;
   redirect_src_e   load_src;
   logic [XLEN-1:0] load_raw;
   logic [XLEN-1:0] pc_d;
   logic            redirected_d;
   logic            addr_fault_d;
   logic [XLEN-1:0] fault_addr_d;

   branch_target_calc #(.XLEN(XLEN)) u_btc (
      .branch_base   (branch_base),
      .branch_imm    (branch_imm),
      .signext       (signext),
      .branch_target (branch_target)
   );

   assign pc_next_seq = pc + XLEN'(INC);
   assign jump_target = {branch_base[XLEN-1:28], jump_index, 2'b00};

   always_comb begin
      req_src    = SRC_SEQ;
      req_target = pc_next_seq;
      if (exception) begin
         req_src    = SRC_EXC;
         req_target = EXC_VECTOR;
      end else if (jump_reg) begin
         req_src    = SRC_JR;
         req_target = jump_reg_target;
      end else if (jump) begin
         req_src    = SRC_J;
         req_target = jump_target;
      end else if (branch_taken) begin
         req_src    = SRC_BR;
         req_target = branch_target;
      end
   end

   // A stalled redirect is parked only if the buffer is empty, so the oldest one wins;
   // the raw target is kept so a misaligned JR still faults when it is finally applied.
   always_comb begin
      pend_valid_d  = pend_valid;
      pend_src_d    = pend_src;
      pend_target_d = pend_target;
      load          = 1'b0;
      load_src      = SRC_SEQ;
      load_raw      = pc_next_seq;
      pc_d          = pc;
      redirected_d  = 1'b0;
      addr_fault_d  = 1'b0;
      fault_addr_d  = fault_addr;

      if (req_src == SRC_EXC) begin
         load         = 1'b1;
         load_src     = SRC_EXC;
         load_raw     = EXC_VECTOR;
         pend_valid_d = 1'b0;
      end else if (stall) begin
         if (req_src != SRC_SEQ && !pend_valid) begin
            pend_valid_d  = 1'b1;
            pend_src_d    = req_src;
            pend_target_d = req_target;
         end
      end else if (pend_valid) begin
         load         = 1'b1;
         load_src     = pend_src;
         load_raw     = pend_target;
         pend_valid_d = 1'b0;
      end else if (req_src != SRC_SEQ) begin
         load     = 1'b1;
         load_src = req_src;
         load_raw = req_target;
      end

      if (load) begin
         redirected_d = 1'b1;
         if (load_src == SRC_JR) begin
            pc_d = align_word(load_raw);
            if (load_raw[1:0] != 2'b00) begin
               addr_fault_d = 1'b1;
               fault_addr_d = load_raw;
            end
         end else begin
            pc_d = load_raw;
         end
      end else if (!stall) begin
         pc_d = pc_next_seq;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc         <= RESET_PC;
         pend_valid <= 1'b0;
         redirected <= 1'b0;
         addr_fault <= 1'b0;
         fault_addr <= '0;
      end else begin
         pc         <= pc_d;
         pend_valid <= pend_valid_d;
         redirected <= redirected_d;
         addr_fault <= addr_fault_d;
         fault_addr <= fault_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      pend_src    <= pend_src_d;
      pend_target <= pend_target_d;
   end

endmodule

// File: tb/tb_pc_nextgen.sv
// Self-checking bench for pc_nextgen: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural PC model.
module tb_pc_nextgen;

   localparam logic [31:0] RST = 32'hBFC0_0000;
   localparam logic [31:0] EXC = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        reset_n, stall, exception, branch_taken, jump, jump_reg;
   logic [31:0] branch_base, jump_reg_target;
   logic [15:0] branch_imm;
   logic [25:0] jump_index;
   logic [31:0] pc, pc_next_seq, signext, branch_target, fault_addr;
   logic        redirected, addr_fault;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model state
   logic [31:0] m_pc, m_pt, m_fa;
   bit          m_pv, m_pjr, m_red, m_af;

   pc_nextgen dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .stall           (stall),
      .exception       (exception),
      .branch_taken    (branch_taken),
      .branch_base     (branch_base),
      .branch_imm      (branch_imm),
      .jump            (jump),
      .jump_index      (jump_index),
      .jump_reg        (jump_reg),
      .jump_reg_target (jump_reg_target),
      .pc              (pc),
      .pc_next_seq     (pc_next_seq),
      .signext         (signext),
      .branch_target   (branch_target),
      .redirected      (redirected),
      .addr_fault      (addr_fault),
      .fault_addr      (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_sext(input logic [15:0] imm);
      int v;
      v = int'($signed(imm));
      return 32'(v);
   endfunction

   function automatic logic [31:0] exp_bt(input logic [31:0] base, input logic [15:0] imm);
      int v;
      v = int'($signed(imm)) * 4;
      return base + 32'(v);
   endfunction

   always @(posedge clk) begin : model
      automatic logic [31:0] tgt;
      automatic bit          req, jr, dlv, djr;
      automatic logic [31:0] dt;
      tgt = 32'h0; req = 1'b0; jr = 1'b0; dlv = 1'b0; djr = 1'b0; dt = 32'h0;
      if (!reset_n) begin
         m_pc  <= RST;
         m_pv  <= 1'b0;
         m_red <= 1'b0;
         m_af  <= 1'b0;
         m_fa  <= 32'h0;
      end else begin
         if (jump_reg) begin
            req = 1'b1; jr = 1'b1; tgt = jump_reg_target;
         end else if (jump) begin
            req = 1'b1; tgt = {branch_base[31:28], jump_index, 2'b00};
         end else if (branch_taken) begin
            req = 1'b1; tgt = exp_bt(branch_base, branch_imm);
         end
         m_red <= 1'b0;
         m_af  <= 1'b0;
         if (exception) begin
            m_pc  <= EXC;
            m_pv  <= 1'b0;
            m_red <= 1'b1;
         end else if (stall) begin
            if (req && !m_pv) begin
               m_pv <= 1'b1; m_pt <= tgt; m_pjr <= jr;
            end
         end else if (m_pv) begin
            dlv = 1'b1; dt = m_pt; djr = m_pjr;
            m_pv <= 1'b0;
         end else if (req) begin
            dlv = 1'b1; dt = tgt; djr = jr;
         end else begin
            m_pc <= m_pc + 32'd4;
         end
         if (dlv) begin
            m_red <= 1'b1;
            m_pc  <= djr ? (dt & 32'hFFFF_FFFC) : dt;
            if (djr && dt[1:0] != 2'b00) begin
               m_af <= 1'b1;
               m_fa <= dt;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc", pc, m_pc);
         chk("redirected", 32'(redirected), 32'(m_red));
         chk("addr_fault", 32'(addr_fault), 32'(m_af));
         chk("fault_addr", fault_addr, m_fa);
         chk("pc_next_seq", pc_next_seq, m_pc + 32'd4);
         chk("signext", signext, exp_sext(branch_imm));
         chk("branch_target", branch_target, exp_bt(branch_base, branch_imm));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; exception = 0; branch_taken = 0; jump = 0; jump_reg = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 0; idle();
      branch_base = 0; branch_imm = 0; jump_index = 0; jump_reg_target = 0;
      step(); step();
      chk_en  = 1'b1;
      reset_n = 1;
      chk("reset_pc", pc, RST);
      chk("reset_red", 32'(redirected), 32'd0);
      chk("reset_fault_addr", fault_addr, 32'h0);
      step(); chk("seq1", pc, 32'hBFC0_0004);
      step(); chk("seq2", pc, 32'hBFC0_0008);
      step(); chk("seq3", pc, 32'hBFC0_000C);
      chk("seq_red", 32'(redirected), 32'd0);

      branch_base = 32'h0040_0010; branch_imm = 16'hFFFE; branch_taken = 1;
      #1;
      chk("br_signext", signext, 32'hFFFF_FFFE);
      chk("br_target", branch_target, 32'h0040_0008);
      step(); idle();
      chk("br_pc", pc, 32'h0040_0008);
      chk("br_red", 32'(redirected), 32'd1);
      step();
      chk("br_seq", pc, 32'h0040_000C);
      chk("br_red_clr", 32'(redirected), 32'd0);

      stall = 1; jump = 1; branch_base = 32'h0040_0000; jump_index = 26'h0000100;
      step();
      jump = 0; branch_taken = 1; branch_base = 32'h0040_0100; branch_imm = 16'h0000;
      step();
      chk("stall_hold", pc, 32'h0040_000C);
      idle();
      step();
      chk("pend_apply", pc, 32'h0000_0400);
      chk("pend_red", 32'(redirected), 32'd1);

      stall = 1; jump = 1; branch_base = 32'h0; jump_index = 26'h0000200;
      step();
      jump = 0; exception = 1; jump_reg = 1; jump_reg_target = 32'h1234_5678; branch_taken = 1;
      step(); idle();
      chk("exc_pc", pc, EXC);
      step();
      chk("exc_pend_clr", pc, 32'h8000_0184);

      jump_reg = 1; jump_reg_target = 32'h0040_1003;
      step(); idle();
      chk("jr_pc", pc, 32'h0040_1000);
      chk("jr_fault", 32'(addr_fault), 32'd1);
      chk("jr_faddr", fault_addr, 32'h0040_1003);
      step();
      chk("jr_fault_pulse", 32'(addr_fault), 32'd0);
      chk("jr_faddr_hold", fault_addr, 32'h0040_1003);

      stall = 1; jump_reg = 1; jump_reg_target = 32'h0040_2002;
      step(); jump_reg = 0;
      step();
      chk("pjr_nofault", 32'(addr_fault), 32'd0);
      idle();
      step();
      chk("pjr_pc", pc, 32'h0040_2000);
      chk("pjr_fault", 32'(addr_fault), 32'd1);
      chk("pjr_faddr", fault_addr, 32'h0040_2002);

      jump_reg = 1; jump_reg_target = 32'hFFFF_FFFC;
      step(); idle();
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      step();
      chk("wrap", pc, 32'h0000_0000);
      stall = 1; jump = 1; branch_base = 32'h0; jump_index = 26'h0000300;
      step();
      jump = 0; reset_n = 0;
      step();
      chk("rst_mid_stall", pc, RST);
      reset_n = 1; idle();
      step();
      chk("rst_no_pend", pc, 32'hBFC0_0004);
      chk("rst_no_red", 32'(redirected), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         reset_n         = ($urandom_range(0, 99) != 0);
         stall           = ($urandom_range(0, 2) == 0);
         exception       = ($urandom_range(0, 24) == 0);
         jump_reg        = ($urandom_range(0, 5) == 0);
         jump            = ($urandom_range(0, 5) == 0);
         branch_taken    = ($urandom_range(0, 4) == 0);
         branch_base     = $urandom;
         branch_imm      = 16'($urandom);
         jump_index      = 26'($urandom);
         jump_reg_target = $urandom;
         step();
      end
      reset_n = 1; idle();
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
